// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared mult/div unit and the HIGH/LOW register writes.
// Optional LastLatency output is enabled by defining MULDIV_CYCLE_COUNT_EN.
module muldiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Req,
  input  logic OpDiv,
  input  logic HiLoRead,
  input  logic MultEnd,
  input  logic DivEnd,
  input  logic DivZero,
  output logic StartMult,
  output logic StartDiv,
  output logic MuxHighSel,
  output logic MuxLowSel,
  output logic WrHigh,
  output logic WrLow,
  output logic Busy,
  output logic Stall,
  output logic DivZeroExc,
  output logic TimeoutErr
`ifdef MULDIV_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] LastLatency
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    WRITE,
    EXC
  } state_t;

  typedef enum logic {
    CAUSE_DIV_ZERO,
    CAUSE_TIMEOUT
  } cause_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  state_t           next_state;
  cause_t           cause;
  logic             op;
  logic [CNT_W-1:0] cnt;
  logic             at_timeout;
  logic             entering_run;
  logic             start_mult_d;
  logic             start_div_d;
  logic             wr_d;
  logic             div_zero_d;
  logic             timeout_d;
  logic             busy_d;

  assign at_timeout   = (cnt == TIMEOUT_VAL);
  assign entering_run = (state == IDLE) && (next_state != IDLE);

  // State register, run counter and latched operation bit.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= 1'b0;
    end else begin
      state <= next_state;
      if (entering_run) begin
        cnt <= CNT_W'(1);
        op  <= OpDiv;
      end else if ((state == MULT_RUN || state == DIV_RUN) && next_state == state) begin
        cnt <= cnt + CNT_W'(1);
      end else if (next_state == IDLE) begin
        cnt <= '0;
      end
    end
  end

  // Next-state logic; flags from the unit that was not started are never looked at.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    next_state = state;
    cause      = CAUSE_TIMEOUT;
    case (state)
      IDLE: begin
        if (Req) next_state = OpDiv ? DIV_RUN : MULT_RUN;
      end
      MULT_RUN: begin
        if (MultEnd)         next_state = WRITE;
        else if (at_timeout) next_state = EXC;
      end
      DIV_RUN: begin
        if (DivZero) begin
          next_state = EXC;
          cause      = CAUSE_DIV_ZERO;
        end else if (DivEnd) begin
          next_state = WRITE;
        end else if (at_timeout) begin
          next_state = EXC;
        end
      end
      WRITE:   next_state = IDLE;
      EXC:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: values the registered outputs take in the next state.
  always_comb begin
    start_mult_d = (state == IDLE) && (next_state == MULT_RUN);
    start_div_d  = (state == IDLE) && (next_state == DIV_RUN);
    wr_d         = (next_state == WRITE);
    div_zero_d   = (next_state == EXC) && (cause == CAUSE_DIV_ZERO);
    timeout_d    = (next_state == EXC) && (cause == CAUSE_TIMEOUT);
    busy_d       = (next_state != IDLE);
    Stall        = Busy & (HiLoRead | Req);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      StartMult  <= 1'b0;
      StartDiv   <= 1'b0;
      WrHigh     <= 1'b0;
      WrLow      <= 1'b0;
      DivZeroExc <= 1'b0;
      TimeoutErr <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      StartMult  <= start_mult_d;
      StartDiv   <= start_div_d;
      WrHigh     <= wr_d;
      WrLow      <= wr_d;
      DivZeroExc <= div_zero_d;
      TimeoutErr <= timeout_d;
      Busy       <= busy_d;
    end
  end

  // The op flop is loaded on entry to RUN and holds through IDLE.
  assign MuxHighSel = op;
  assign MuxLowSel  = op;

`ifdef MULDIV_CYCLE_COUNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      LastLatency <= '0;
    end else if ((state == MULT_RUN || state == DIV_RUN) &&
                 (next_state == WRITE || next_state == EXC)) begin
      LastLatency <= cnt;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_muldiv_ctrl;

  localparam int TO    = 40;
  localparam int CNT_W = 7;

  logic Clk, Reset, Req, OpDiv, HiLoRead, MultEnd, DivEnd, DivZero;
  logic StartMult, StartDiv, MuxHighSel, MuxLowSel, WrHigh, WrLow;
  logic Busy, Stall, DivZeroExc, TimeoutErr;
`ifdef MULDIV_CYCLE_COUNT_EN
  logic [CNT_W-1:0] LastLatency;
`endif

  muldiv_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .OpDiv      (OpDiv),
    .HiLoRead   (HiLoRead),
    .MultEnd    (MultEnd),
    .DivEnd     (DivEnd),
    .DivZero    (DivZero),
    .StartMult  (StartMult),
    .StartDiv   (StartDiv),
    .MuxHighSel (MuxHighSel),
    .MuxLowSel  (MuxLowSel),
    .WrHigh     (WrHigh),
    .WrLow      (WrLow),
    .Busy       (Busy),
    .Stall      (Stall),
    .DivZeroExc (DivZeroExc),
    .TimeoutErr (TimeoutErr)
`ifdef MULDIV_CYCLE_COUNT_EN
    ,
    .LastLatency(LastLatency)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level model: an operation is in flight, has run for run_m
  // cycles, and either finishes, faults or times out per the exit rules.
  bit e_busy = 0, running = 0, op_m = 0;
  bit e_sm = 0, e_sd = 0, e_wr = 0, e_dz = 0, e_to = 0;
  int run_m = 0, lat_m = 0;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      e_busy = 0; running = 0; op_m = 0; run_m = 0; lat_m = 0;
      e_sm = 0; e_sd = 0; e_wr = 0; e_dz = 0; e_to = 0;
    end else begin
      e_sm = 0; e_sd = 0; e_wr = 0; e_dz = 0; e_to = 0;
      if (running) begin
        if (op_m && DivZero) begin
          running = 0; e_dz = 1; lat_m = run_m;
        end else if (op_m ? DivEnd : MultEnd) begin
          running = 0; e_wr = 1; lat_m = run_m;
        end else if (run_m == TO) begin
          running = 0; e_to = 1; lat_m = run_m;
        end else begin
          run_m++;
        end
      end else if (e_busy) begin
        e_busy = 0;
      end else if (Req) begin
        e_busy = 1; running = 1; op_m = OpDiv; run_m = 1;
        e_sm = !OpDiv; e_sd = OpDiv;
      end
    end
  end

  int n_sm = 0, n_sd = 0, n_wr = 0, n_dz = 0, n_to = 0;

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("busy", Busy, e_busy);
      check("start_mult", StartMult, e_sm);
      check("start_div", StartDiv, e_sd);
      check("wr_high", WrHigh, e_wr);
      check("wr_low", WrLow, e_wr);
      check("mux_high", MuxHighSel, op_m);
      check("mux_low", MuxLowSel, op_m);
      check("div_zero_exc", DivZeroExc, e_dz);
      check("timeout_err", TimeoutErr, e_to);
      check("stall", Stall, e_busy & (HiLoRead | Req));
`ifdef MULDIV_CYCLE_COUNT_EN
      check("last_latency", 32'(LastLatency), lat_m);
`endif
      n_sm += int'(StartMult); n_sd += int'(StartDiv); n_wr += int'(WrHigh);
      n_dz += int'(DivZeroExc); n_to += int'(TimeoutErr);
    end
  end

  task automatic clr();
    Req = 0; OpDiv = 0; HiLoRead = 0; MultEnd = 0; DivEnd = 0; DivZero = 0;
  endtask

  task automatic clr_cnt();
    n_sm = 0; n_sd = 0; n_wr = 0; n_dz = 0; n_to = 0;
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic lat_check(input string name, input int req);
`ifdef MULDIV_CYCLE_COUNT_EN
    check(name, 32'(LastLatency), req);
`endif
  endtask

  // Runs a mult that ends on run cycle end_cyc, or times out when end_cyc == 0.
  task automatic run_mult(input int end_cyc);
    clr_cnt();
    Req = 1; OpDiv = 0; step(); clr();
    check("lit_mult_start", StartMult, 1);
    if (end_cyc == 0) begin
      step(TO);
      check("lit_to_pulse", TimeoutErr, 1);
      check("lit_to_nowr", WrHigh, 0);
      lat_check("lit_to_lat", TO);
    end else begin
      step(end_cyc - 1);
      MultEnd = 1; step(); clr();
      check("lit_mult_wr", {WrHigh, WrLow, MuxHighSel, MuxLowSel, TimeoutErr}, 5'b11000);
      lat_check("lit_mult_lat", end_cyc);
    end
    step();
    check("lit_mult_idle", Busy, 0);
    check("lit_mult_nsm", n_sm, 1);
  endtask

  initial begin
    clr();
    Reset = 1;
    #3 Reset = 0;
    cmp_en = 1;
    #1;
    check("lit_rst_busy", Busy, 0);
    check("lit_rst_outs", {StartMult, StartDiv, WrHigh, WrLow, DivZeroExc, TimeoutErr, Stall}, 0);
    step(2);
    Reset = 1;
    step();

    // Normal mult, done on run cycle 33; then watchdog boundary cases.
    run_mult(33);
    run_mult(0);
    check("lit_to_once", n_to, 1);
    run_mult(TO);
    check("lit_done_wins", n_to, 0);
    run_mult(1);

    // Normal div, done on run cycle 5.
    clr_cnt();
    Req = 1; OpDiv = 1; step(); clr();
    check("lit_div_start", StartDiv, 1);
    step(4);
    DivEnd = 1; step(); clr();
    check("lit_div_wr", {WrHigh, WrLow, MuxHighSel, MuxLowSel, DivZeroExc}, 5'b11110);
    lat_check("lit_div_lat", 5);
    step();
    check("lit_div_nsd", n_sd, 1);

    // Divide by zero with DivEnd in the same cycle.
    clr_cnt();
    Req = 1; OpDiv = 1; step(); clr();
    step();
    DivZero = 1; DivEnd = 1; step(); clr();
    check("lit_dz_pulse", {DivZeroExc, TimeoutErr, WrHigh}, 3'b100);
    step();
    check("lit_dz_idle", Busy, 0);
    check("lit_dz_nwr", n_wr, 0);
    check("lit_dz_ndz", n_dz, 1);

    // Interlock: read and second request while dividing.
    clr_cnt();
    Req = 1; OpDiv = 1; step(); clr();
    HiLoRead = 1; Req = 1; OpDiv = 0;
    #1 check("lit_stall_hi", Stall, 1);
    step(); clr();
    check("lit_req_ignored", {StartMult, StartDiv, Busy}, 3'b001);
    DivEnd = 1; step(); clr();
    check("lit_il_wr", {WrHigh, MuxHighSel}, 2'b11);
    step();
    HiLoRead = 1;
    #1 check("lit_stall_lo", Stall, 0);
    clr();

    // Asynchronous reset on run cycle 3 of a mult.
    clr_cnt();
    Req = 1; OpDiv = 0; step(); clr();
    step(2);
    #2 Reset = 0;
    #1 check("lit_mid_rst", {Busy, StartMult, WrHigh, WrLow, TimeoutErr}, 0);
    Reset = 1;
    MultEnd = 1; step(); clr();
    check("lit_late_end", {WrHigh, Busy}, 0);
    Req = 1; OpDiv = 0; step(); clr();
    check("lit_fresh_req", StartMult, 1);
    MultEnd = 1; step(); clr();
    check("lit_min_lat", WrHigh, 1);
    step();

    // Random traffic; some stretches withhold done flags to force timeouts.
    begin
      bit hang = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c % 150 == 0) hang = ($urandom_range(0, 3) == 0);
        Req      = ($urandom_range(0, 2) == 0);
        OpDiv    = $urandom_range(0, 1);
        HiLoRead = ($urandom_range(0, 3) == 0);
        MultEnd  = !hang && ($urandom_range(0, 7) == 0);
        DivEnd   = !hang && ($urandom_range(0, 7) == 0);
        DivZero  = !hang && ($urandom_range(0, 19) == 0);
        if (c % 1000 == 777) begin
          #2 Reset = 0;
          #1 Reset = 1;
          step();
        end else begin
          step();
        end
      end
    end
    clr();
    step(TO + 5);
    check("lit_end_idle", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the shared mult/div resource and the HIGH/LOW registers in the multicycle CPU datapath.
- Accepts one-cycle mult/div requests from the control unit and pulses the start of the selected unit.
- Waits for that unit's done flag, then writes HIGH/LOW through the Div/Mult select muxes.
- Reports busy, stall, divide-by-zero and watchdog-timeout status back to the control unit.

Parameters:
- TIMEOUT_CYCLES, 64, run cycles allowed before the watchdog aborts the operation.
- CNT_W, 7, width of the run-cycle counter; must hold TIMEOUT_CYCLES.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  control-unit request pulse.
- OpDiv  in  1  operation select, sampled with Req: 0 = mult, 1 = div.
- HiLoRead  in  1  control unit wants HIGH/LOW this cycle (mfhi/mflo).
- MultEnd  in  1  mult unit done.
- DivEnd  in  1  div unit done.
- DivZero  in  1  div unit divide-by-zero flag.
- StartMult  out  1  start pulse to the mult unit.
- StartDiv  out  1  start pulse to the div unit.
- MuxHighSel  out  1  HIGH source: 0 = mult, 1 = div.
- MuxLowSel  out  1  LOW source: 0 = mult, 1 = div.
- WrHigh  out  1  HIGH register load.
- WrLow  out  1  LOW register load.
- Busy  out  1  operation in flight.
- Stall  out  1  control unit must hold its state.
- DivZeroExc  out  1  one-cycle divide-by-zero exception pulse.
- TimeoutErr  out  1  one-cycle watchdog abort pulse.

Behaviour:
- States: IDLE, MULT_RUN, DIV_RUN, WRITE, EXC.
- All outputs are registered except Stall.
- Reset (Reset=0), at any time including mid-operation:
  - state goes to IDLE and the counter clears.
  - all outputs are 0.
  - no HIGH/LOW write is issued.
- IDLE:
  - Req=1 at an edge moves to MULT_RUN (OpDiv=0) or DIV_RUN (OpDiv=1).
  - The operation type is latched into an internal op bit.
  - Req=0 keeps IDLE.
- Start pulse: StartMult or StartDiv is high for exactly the first RUN cycle (one cycle after the Req edge), then low.
- Run counter: loads 1 on the first RUN cycle, then increments once per RUN cycle.
- Exits from MULT_RUN, priority order:
  - MultEnd=1 -> WRITE.
  - counter == TIMEOUT_CYCLES -> EXC with timeout cause.
  - otherwise stay.
- Exits from DIV_RUN, priority order:
  - DivZero=1 -> EXC with div-zero cause.
  - DivEnd=1 -> WRITE.
  - counter == TIMEOUT_CYCLES -> EXC with timeout cause.
  - otherwise stay.
- Done and timeout in the same cycle: done wins.
- End/Zero flags from the unit that was not started are ignored.
- WRITE:
  - lasts one cycle; WrHigh=WrLow=1.
  - MuxHighSel=MuxLowSel=latched op bit.
  - next state IDLE.
- Mux selects hold the latched op bit from the first RUN cycle through WRITE. In IDLE they hold their last value.
- EXC:
  - lasts one cycle.
  - DivZeroExc=1 or TimeoutErr=1 according to cause, never both.
  - no HIGH/LOW write.
  - next state IDLE.
- Busy is 1 in MULT_RUN, DIV_RUN, WRITE and EXC; 0 in IDLE.
- Stall = Busy & (HiLoRead | Req). This is a combinational output.
- Req while Busy=1 is ignored (not queued). The control unit must re-issue it after Stall drops.
- Minimum latency from Req edge to WrHigh: 2 cycles, i.e. done on the first RUN cycle.
- Back-to-back: Req may be accepted in the IDLE cycle immediately after WRITE or EXC.

Optional Feature:
- Macro: MULDIV_CYCLE_COUNT_EN.
- When defined, adds output LastLatency [CNT_W-1:0]:
  - loaded with the run counter value on entry to WRITE or EXC.
  - holds that value otherwise.
  - reset value 0.
- When undefined, the port and its register do not exist; all other behaviour is identical.

Test Plan:
- Mult, normal completion: Req=1, OpDiv=0; MultEnd raised on run cycle 33 -> StartMult high exactly 1 cycle; WrHigh=WrLow=1 with MuxHighSel=MuxLowSel=0 one cycle after MultEnd; Busy drops next cycle; LastLatency=33 if enabled.
- Div, normal completion: Req=1, OpDiv=1; DivEnd raised on run cycle 5 -> StartDiv single pulse; write cycle with selects=1; no DivZeroExc.
- Div by zero: Req=1, OpDiv=1; DivZero=1 and DivEnd=1 on run cycle 2 -> DivZeroExc one-cycle pulse; WrHigh/WrLow never asserted; IDLE afterwards.
- Watchdog: TIMEOUT_CYCLES=8; mult with MultEnd never asserted -> TimeoutErr pulse after run cycle 8, no write. Repeat with MultEnd=1 exactly on run cycle 8 -> write occurs, no TimeoutErr.
- Interlock: during DIV_RUN, drive HiLoRead=1 and a second Req -> Stall=1 in the same cycle; second Req not accepted; Stall=0 once IDLE.
- Reset mid-operation: Reset=0 asynchronously on run cycle 3 of a mult -> all outputs 0 immediately; after release with a late MultEnd=1 -> no write; fresh Req accepted normally.
